btn_op_capture: RTL and testbench

- Front-end stage that sits directly upstream of project_1, the ALU/bit-function stage.
- Synchronises the 16 slide switches and 5 push buttons, and debounces each button.
- Turns a clean button press into a registered operation code plus a switch-operand snapshot.
- Emits a one-cycle op_valid strobe so the downstream stage sees stable operands for the whole time a result is displayed.

---
 rtl/btn_op_pkg.sv | 40 ++++
 rtl/btn_op_capture_debounce.sv | 52 +++++
 rtl/btn_op_capture.sv | 121 ++++++++++++
 tb/tb_btn_op_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_op_pkg.sv
// Shared types and constants for the button/switch operation capture front end.
package btn_op_pkg;

  // Operation codes understood by the downstream ALU/bit-function stage.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LO   = 3'd1,
    OP_NO   = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MULT = 3'd5
  } op_t;

  // Capture FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Button indices; a lower index wins when several presses coincide.
  localparam int NUM_BTNS = 5;
  localparam int BTN_C    = 0;
  localparam int BTN_U    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_L    = 3;
  localparam int BTN_R    = 4;

  // Operation selected by each button.
  function automatic op_t btn_to_op(input int idx);
    case (idx)
      BTN_C:   return OP_MULT;
      BTN_U:   return OP_LO;
      BTN_D:   return OP_NO;
      BTN_L:   return OP_ADD;
      BTN_R:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_op_capture_debounce.sv
// Per-button synchroniser, debounce counter and stable-state edge detector.
module debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic [CNT_W-1:0]       cnt;
  logic                   stable_prev;
  logic                   synced;

  assign synced = sync_chain[SYNC_STAGES-1];

  // Shift the asynchronous button level through the synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
  end

  // Count consecutive mismatching cycles; flip the stable level after a full run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Remember last cycle's stable level so a rising edge can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_prev <= 1'b0;
    else       stable_prev <= stable;
  end

  assign press_pulse = stable & ~stable_prev;

endmodule

// File: rtl/btn_op_capture.sv
// Debounces five buttons and captures an operation code plus switch snapshot per press.
module btn_op_capture
  import btn_op_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] sw_q,
  output logic [2:0]      op,
  output logic            op_valid,
  output logic            btn_held
);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] stable;
  logic [NUM_BTNS-1:0] press;
  logic [BITS-1:0]     sw_pipe [SYNC_STAGES];
  logic [BITS-1:0]     sw_sync;
  state_t              state, state_n;
  op_t                 op_r, op_n, sel_op;
  logic [BITS-1:0]     sw_n;
  logic                vld_n;
  logic                any_press;

  // Gather the raw buttons into a vector ordered by priority index.
  always_comb begin
    raw_btn        = '0;
    raw_btn[BTN_C] = BTNC;
    raw_btn[BTN_U] = BTNU;
    raw_btn[BTN_D] = BTND;
    raw_btn[BTN_L] = BTNL;
    raw_btn[BTN_R] = BTNR;
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_btn[g]),
      .stable     (stable[g]),
      .press_pulse(press[g])
    );
  end

  // Synchronise the switches; they are levels, so no debouncing is applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_pipe[i] <= '0;
    end else begin
      sw_pipe[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) sw_pipe[i] <= sw_pipe[i-1];
    end
  end

  assign sw_sync = sw_pipe[SYNC_STAGES-1];

  // Pick the highest-priority press event of this cycle (lowest index wins).
  always_comb begin
    sel_op    = OP_NONE;
    any_press = 1'b0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (press[i]) begin
        sel_op    = btn_to_op(i);
        any_press = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the capture FSM.
  always_comb begin
    state_n = state;
    op_n    = op_r;
    sw_n    = sw_q;
    vld_n   = 1'b0;
    case (state)
      IDLE: begin
        if (any_press) begin
          op_n    = sel_op;
          sw_n    = sw_sync;
          vld_n   = 1'b1;
          state_n = HELD;
        end
      end
      HELD: begin
        if (stable == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Register FSM state and the captured operation/operand outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= OP_NONE;
      sw_q     <= '0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_n;
      op_r     <= op_n;
      sw_q     <= sw_n;
      op_valid <= vld_n;
    end
  end

  assign op       = op_r;
  assign btn_held = (state == HELD);

endmodule

// File: tb/tb_btn_op_capture.sv
// Self-checking bench for btn_op_capture with directed steps and random stimulus.
module tb_btn_op_capture;

  localparam int BITS = 16;
  localparam int S    = 2;
  localparam int D    = 4;

  // Operation codes as stated for the downstream stage.
  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_LO   = 3'd1;
  localparam logic [2:0] E_ADD  = 3'd3;
  localparam logic [2:0] E_SUB  = 3'd4;
  localparam logic [2:0] E_MULT = 3'd5;

  logic            clk = 1'b0;
  logic            reset;
  logic [BITS-1:0] SW;
  logic            BTNC, BTNU, BTND, BTNL, BTNR;
  logic [BITS-1:0] sw_q;
  logic [2:0]      op;
  logic            op_valid;
  logic            btn_held;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_count = 0;
  logic last_vld = 1'b0;

  btn_op_capture #(
    .BITS(BITS), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .SW(SW),
    .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .sw_q(sw_q), .op(op), .op_valid(op_valid), .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buttons listed in priority order: C, U, D, L, R.
  logic [4:0]  m_stable, m_prev;
  int          m_run [5];
  logic [20:0] m_hist [$];   // {SW, buttons} as seen at each past edge
  logic        m_held, m_vld;
  logic [2:0]  m_op;
  logic [15:0] m_sw;

  function automatic logic [2:0] op_of(input int i);
    case (i)
      0:       return E_MULT;
      1:       return E_LO;
      2:       return 3'd2;
      3:       return E_ADD;
      default: return E_SUB;
    endcase
  endfunction

  function automatic logic [4:0] btn_vec();
    return {BTNR, BTNL, BTND, BTNU, BTNC};
  endfunction

  task automatic model_reset();
    m_stable = '0;
    m_prev   = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back('0);
    m_held = 1'b0;
    m_vld  = 1'b0;
    m_op   = E_NONE;
    m_sw   = '0;
  endtask

  task automatic model_edge();
    logic [20:0] old;
    logic        found;
    if (reset) begin
      model_reset();
      return;
    end
    old = m_hist.pop_front();
    m_hist.push_back({SW, btn_vec()});
    m_vld = 1'b0;
    if (!m_held) begin
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (!found && m_stable[i] && !m_prev[i]) begin
          found  = 1'b1;
          m_op   = op_of(i);
          m_sw   = old[20:5];
          m_vld  = 1'b1;
          m_held = 1'b1;
        end
      end
    end else if (m_stable == '0) begin
      m_held = 1'b0;
    end
    m_prev = m_stable;
    for (int i = 0; i < 5; i++) begin
      if (old[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stable[i] = ~m_stable[i];
          m_run[i]    = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".op_valid"}, {31'd0, op_valid}, {31'd0, m_vld});
    chk({tag, ".op"},       {29'd0, op},       {29'd0, m_op});
    chk({tag, ".sw_q"},     {16'd0, sw_q},     {16'd0, m_sw});
    chk({tag, ".btn_held"}, {31'd0, btn_held}, {31'd0, m_held});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
    chk({tag, ".vld_back_to_back"}, {31'd0, op_valid & last_vld}, 32'd0);
    if (op_valid) vld_count++;
    last_vld = op_valid;
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_btns(input logic [4:0] b);
    {BTNR, BTNL, BTND, BTNU, BTNC} = b;
  endtask

  // Step until op_valid is seen; n = steps taken, or -1 if the budget expires.
  task automatic wait_vld(input string tag, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(tag);
      if (op_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Step until btn_held drops; n = steps taken, or -1 if the budget expires.
  task automatic wait_release(input string tag, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(tag);
      if (!btn_held) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int v0;
    logic [4:0] rb;
    int len;

    // Test 1: reset with random inputs, then quiet idle.
    reset = 1'b1;
    SW    = BITS'($urandom);
    set_btns(5'($urandom));
    model_reset();
    #1;
    chk("t1_async_rst.sw_q", {16'd0, sw_q}, 32'd0);
    chk("t1_async_rst.op", {29'd0, op}, {29'd0, E_NONE});
    chk("t1_async_rst.op_valid", {31'd0, op_valid}, 32'd0);
    chk("t1_async_rst.btn_held", {31'd0, btn_held}, 32'd0);
    steps("t1_rst", 4);
    set_btns(5'b00000);
    reset = 1'b0;
    steps("t1_idle", 50);
    chk("t1_idle_vld_count", vld_count, 32'd0);

    // Test 2: clean BTNL press, exact latency, then release.
    SW = 16'h0305;
    set_btns(5'b01000);
    wait_vld("t2_press", 20, n);
    chk("t2_latency", n, 32'd7);
    v0 = vld_count;
    steps("t2_hold", 12);
    chk("t2_single_strobe", vld_count - v0, 32'd0);
    chk("t2_op", {29'd0, op}, {29'd0, E_ADD});
    chk("t2_sw_q", {16'd0, sw_q}, 32'h0305);
    chk("t2_held", {31'd0, btn_held}, 32'd1);
    set_btns(5'b00000);
    wait_release("t2_release", 20, n);
    chk("t2_release_latency", n, 32'd7);
    chk("t2_op_kept", {29'd0, op}, {29'd0, E_ADD});
    steps("t2_idle", 5);

    // Test 3: bouncing BTNU, then a solid hold.
    SW = 16'h00A5;
    v0 = vld_count;
    for (int i = 0; i < 12; i++) begin
      set_btns(((i / 2) % 2 == 0) ? 5'b00010 : 5'b00000);
      step("t3_bounce");
    end
    chk("t3_no_strobe_bouncing", vld_count - v0, 32'd0);
    set_btns(5'b00010);
    steps("t3_hold", 20);
    chk("t3_one_strobe", vld_count - v0, 32'd1);
    chk("t3_op", {29'd0, op}, {29'd0, E_LO});
    chk("t3_sw_q", {16'd0, sw_q}, 32'h00A5);
    set_btns(5'b00000);
    steps("t3_release", 15);

    // Test 4: BTND glitch shorter than the debounce window.
    v0 = vld_count;
    SW = 16'h1234;
    set_btns(5'b00100);
    steps("t4_glitch", 3);
    set_btns(5'b00000);
    steps("t4_after", 15);
    chk("t4_no_strobe", vld_count - v0, 32'd0);
    chk("t4_op_kept", {29'd0, op}, {29'd0, E_LO});
    chk("t4_sw_kept", {16'd0, sw_q}, 32'h00A5);

    // Test 5: simultaneous C+R, press U while held, later R alone.
    SW = 16'hFF02;
    v0 = vld_count;
    set_btns(5'b10001);
    steps("t5_cr", 15);
    chk("t5_cr_strobe", vld_count - v0, 32'd1);
    chk("t5_op_mult", {29'd0, op}, {29'd0, E_MULT});
    chk("t5_sw_q", {16'd0, sw_q}, 32'hFF02);
    v0 = vld_count;
    set_btns(5'b10011);
    steps("t5_u_ignored", 15);
    chk("t5_u_no_strobe", vld_count - v0, 32'd0);
    chk("t5_op_still_mult", {29'd0, op}, {29'd0, E_MULT});
    set_btns(5'b00000);
    steps("t5_release", 15);
    chk("t5_idle", {31'd0, btn_held}, 32'd0);
    v0 = vld_count;
    set_btns(5'b10000);
    steps("t5_r", 15);
    chk("t5_r_strobe", vld_count - v0, 32'd1);
    chk("t5_op_sub", {29'd0, op}, {29'd0, E_SUB});
    set_btns(5'b00000);
    steps("t5_r_release", 15);

    // Test 6: SW change while held, reset mid-HELD, button held through reset.
    SW = 16'h0101;
    set_btns(5'b01000);
    steps("t6_press", 12);
    SW = 16'h7F7F;
    steps("t6_sw_change", 5);
    chk("t6_sw_kept", {16'd0, sw_q}, 32'h0101);
    chk("t6_held", {31'd0, btn_held}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_async_rst.sw_q", {16'd0, sw_q}, 32'd0);
    chk("t6_async_rst.op", {29'd0, op}, {29'd0, E_NONE});
    chk("t6_async_rst.btn_held", {31'd0, btn_held}, 32'd0);
    chk("t6_async_rst.op_valid", {31'd0, op_valid}, 32'd0);
    steps("t6_in_rst", 3);
    reset = 1'b0;
    wait_vld("t6_repress", 20, n);
    chk("t6_repress_latency", n, 32'd7);
    chk("t6_repress_op", {29'd0, op}, {29'd0, E_ADD});
    chk("t6_repress_sw", {16'd0, sw_q}, 32'h7F7F);
    set_btns(5'b00000);
    steps("t6_release", 15);

    // Random phase: bouncy multi-button activity, switch churn, occasional reset.
    for (int seg = 0; seg < 120; seg++) begin
      rb  = 5'($urandom);
      if ($urandom_range(0, 2) == 0) rb = '0;
      set_btns(rb);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) SW = BITS'($urandom);
        step("rnd");
      end
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("rnd_async_rst");
        steps("rnd_rst", 2);
        reset = 1'b0;
      end
    end
    set_btns(5'b00000);
    steps("rnd_drain", 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
